decode_stage_pipe: RTL

//  Parametrised pipelined decode stage: register file with write-back bypass,

---
 rtl/decode_stage_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// ============================================================================
// decode_stage_pipe
// ----------------------------------------------------------------------------
// Decode stage of an in-order pipeline: register file with write-back bypass,
// load-use hazard detection, and the ID/EX pipeline register. The stage
// consumes the instruction and its externally decoded control and immediate.
// One cycle later it presents registered operands and control to execute.
// It also tells fetch to hold when a load result is not yet available.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   InstrD            instruction word (rs1=[19:15], rs2=[24:20], rd=[11:7])
//   ValidD            InstrD holds a real instruction
//   CtrlD             packed control bundle; CtrlD[LOAD_BIT] marks a load
//   Rs1UsedD/Rs2UsedD instruction reads rs1 / rs2
//   ImmExtD, PCD      immediate and PC passed through to execute
//   RegWriteW/RdW/ResultW  write-back port (also feeds the read bypass)
//   FlushE            squash the instruction entering execute
//   StallD            hold PC and IF/ID (combinational)
//   ValidE, CtrlE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE
//                     ID/EX register contents
//   a0                register 10 as stored (no bypass)
//   StallCount        saturating count of stalled cycles
// ============================================================================
module decode_stage_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5,
    parameter int CTRL_W     = 12,
    parameter int LOAD_BIT   = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           InstrD,
    input  logic                  ValidD,
    input  logic [CTRL_W-1:0]     CtrlD,
    input  logic                  Rs1UsedD,
    input  logic                  Rs2UsedD,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic                  RegWriteW,
    input  logic [ADDR_W-1:0]     RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  FlushE,
    output logic                  StallD,
    output logic                  ValidE,
    output logic [CTRL_W-1:0]     CtrlE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [ADDR_W-1:0]     Rs1E,
    output logic [ADDR_W-1:0]     Rs2E,
    output logic [ADDR_W-1:0]     RdE,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] a0,
    output logic [CNT_W-1:0]      StallCount
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic [DATA_WIDTH-1:0] rf_d [NREG];

    logic                  valid_q,  valid_d;
    logic [CTRL_W-1:0]     ctrl_q,   ctrl_d;
    logic [DATA_WIDTH-1:0] rd1_q,    rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q,    rd2_d;
    logic [ADDR_W-1:0]     rs1e_q,   rs1e_d;
    logic [ADDR_W-1:0]     rs2e_q,   rs2e_d;
    logic [ADDR_W-1:0]     rde_q,    rde_d;
    logic [DATA_WIDTH-1:0] imm_q,    imm_d;
    logic [DATA_WIDTH-1:0] pc_q,     pc_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;

    logic [ADDR_W-1:0]     rs1, rs2, rd;
    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic                  haz;
    logic                  bubble;

    // Only the register-index fields of the instruction matter here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

    assign rs1 = InstrD[15 +: ADDR_W];
    assign rs2 = InstrD[20 +: ADDR_W];
    assign rd  = InstrD[7  +: ADDR_W];

    // ---- Stage D: register read with write-first bypass, hazard detection ----
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != '0) begin
            rd1 = (RegWriteW && (RdW == rs1)) ? ResultW : rf_q[rs1];
        end
        if (rs2 != '0) begin
            rd2 = (RegWriteW && (RdW == rs2)) ? ResultW : rf_q[rs2];
        end

        // A load sitting in EX cannot forward in time to a dependent instruction.
        haz = ValidD && valid_q && ctrl_q[LOAD_BIT] && (rde_q != '0) &&
              ((Rs1UsedD && (rs1 == rde_q)) || (Rs2UsedD && (rs2 == rde_q)));

        // The flush (fetch redirect) takes priority over the stall.
        StallD = haz && !FlushE;
        bubble = FlushE || haz || !ValidD;
    end

    always_comb begin
        rf_d = rf_q;
        if (RegWriteW && (RdW != '0)) begin
            rf_d[RdW] = ResultW;
        end

        valid_d = 1'b0;
        ctrl_d  = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        rs1e_d  = '0;
        rs2e_d  = '0;
        rde_d   = '0;
        imm_d   = '0;
        pc_d    = '0;
        if (!bubble) begin
            valid_d = 1'b1;
            ctrl_d  = CtrlD;
            rd1_d   = rd1;
            rd2_d   = rd2;
            rs1e_d  = rs1;
            rs2e_d  = rs2;
            rde_d   = rd;
            imm_d   = ImmExtD;
            pc_d    = PCD;
        end

        // Saturate at all-ones rather than wrapping.
        cnt_d = cnt_q;
        if (StallD && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ---- Stage D -> E: ID/EX register, register file, stall counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rs1e_q  <= '0;
            rs2e_q  <= '0;
            rde_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            rf_q    <= rf_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            rs1e_q  <= rs1e_d;
            rs2e_q  <= rs2e_d;
            rde_q   <= rde_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ValidE     = valid_q;
    assign CtrlE      = ctrl_q;
    assign RD1E       = rd1_q;
    assign RD2E       = rd2_q;
    assign Rs1E       = rs1e_q;
    assign Rs2E       = rs2e_q;
    assign RdE        = rde_q;
    assign ImmExtE    = imm_q;
    assign PCE        = pc_q;
    assign StallCount = cnt_q;
    assign a0         = rst ? '0 : rf_q[ADDR_W'(10)];

endmodule
